// File: rtl/sbmips_pkg.sv
// sbmips_pkg: shared opcode/funct constants, led source encoding and word type
package sbmips_pkg;
  typedef logic [31:0] word_t;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [2:0] {
    LED_PC    = 3'd0,
    LED_R_LO  = 3'd1,
    LED_R_MID = 3'd2,
    LED_R_HI  = 3'd3,
    LED_INSTR = 3'd4,
    LED_CYC   = 3'd5,
    LED_Z6    = 3'd6,
    LED_Z7    = 3'd7
  } led_src_e;
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, $0 hardwired to zero, two operand ports plus a debug read port
module regfile
  import sbmips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [4:0] wa,
  input  word_t      wd,
  input  logic [4:0] ra1,
  input  logic [4:0] ra2,
  input  logic [4:0] ra3,
  output word_t      rd1,
  output word_t      rd2,
  output word_t      rd3
);
  word_t r_q [32];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 32; i++) r_q[i] <= '0;
    else if (we && wa != 5'd0)
      r_q[wa] <= wd;
  assign rd1 = (ra1 == 5'd0) ? '0 : r_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : r_q[ra2];
  assign rd3 = (ra3 == 5'd0) ? '0 : r_q[ra3];
endmodule

// File: rtl/top.sv
// top: single-cycle sbmips core with instruction ROM, data RAM and an LED debug mux
module top
  import sbmips_pkg::*;
#(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = "imem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gclk,
  input  logic [7:0]  led_sel,
  output logic [11:0] led
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam word_t PC_MASK = word_t'(IMEM_WORDS * 4 - 1);
  word_t rom [IMEM_WORDS];
  word_t ram [DMEM_WORDS];
  word_t pc_q, pc_d, cyc_q, instr, rs_v, rt_v, dbg_v, wd, pc4, imm_s, ea;
  logic [4:0] wa;
  logic [5:0] op, fn;
  logic we, mem_we;
  logic [DAW-1:0] daddr;
  assign instr = rom[pc_q[IAW+1:2]];
  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign imm_s = {{16{instr[15]}}, instr[15:0]};
  assign pc4   = pc_q + 32'd4;
  assign ea    = rs_v + imm_s;
  assign daddr = ea[DAW+1:2];
  regfile u_rf (
    .clk  (clk),
    .rst_n(rst),
    .we   (we && gclk),
    .wa   (wa),
    .wd   (wd),
    .ra1  (instr[25:21]),
    .ra2  (instr[20:16]),
    .ra3  (led_sel[4:0]),
    .rd1  (rs_v),
    .rd2  (rt_v),
    .rd3  (dbg_v)
  );
  always_comb begin
    wa     = instr[20:16];
    wd     = '0;
    we     = 1'b0;
    mem_we = 1'b0;
    pc_d   = pc4;
    case (op)
      OP_R: begin
        wa = instr[15:11];
        we = 1'b1;
        case (fn)
          FN_ADDU: wd = rs_v + rt_v;
          FN_SUBU: wd = rs_v - rt_v;
          FN_AND:  wd = rs_v & rt_v;
          FN_OR:   wd = rs_v | rt_v;
          FN_SLT:  wd = {31'd0, $signed(rs_v) < $signed(rt_v)};
          FN_SLL:  wd = rt_v << instr[10:6];
          default: we = 1'b0;
        endcase
      end
      OP_ADDIU: begin we = 1'b1; wd = ea; end
      OP_ORI:   begin we = 1'b1; wd = rs_v | {16'd0, instr[15:0]}; end
      OP_LUI:   begin we = 1'b1; wd = {instr[15:0], 16'd0}; end
      OP_LW:    begin we = 1'b1; wd = ram[daddr]; end
      OP_SW:    mem_we = 1'b1;
      OP_BEQ:   pc_d = (rs_v == rt_v) ? pc4 + (imm_s << 2) : pc4;
      OP_BNE:   pc_d = (rs_v != rt_v) ? pc4 + (imm_s << 2) : pc4;
      OP_J:     pc_d = {pc4[31:28], instr[25:0], 2'b00};
      default:  pc_d = pc4;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q  <= '0;
      cyc_q <= '0;
    end else if (gclk) begin
      pc_q  <= pc_d & PC_MASK;
      cyc_q <= cyc_q + 32'd1;
    end
  always_ff @(posedge clk)
    if (rst && gclk && mem_we) ram[daddr] <= rt_v;
  always_comb
    case (led_src_e'(led_sel[7:5]))
      LED_PC:    led = pc_q[11:0];
      LED_R_LO:  led = dbg_v[11:0];
      LED_R_MID: led = dbg_v[23:12];
      LED_R_HI:  led = {4'd0, dbg_v[31:24]};
      LED_INSTR: led = instr[11:0];
      LED_CYC:   led = cyc_q[11:0];
      default:   led = '0;
    endcase
endmodule

// File: tb/tb_top.sv
// tb_top: directed and randomized checks of top against an instruction-level model
module tb_top;
  logic clk = 1'b0, rst = 1'b0, gclk = 1'b0;
  logic [7:0] led_sel = '0;
  logic [11:0] led;
  int vec = 0, bad = 0;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] prog [64];
  logic [31:0] m_pc, m_cyc;

  top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (
    .clk(clk), .rst(rst), .gclk(gclk), .led_sel(led_sel), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input int rs, rt, rd, sh, fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i_ins(input int op, rs, rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;
    m_cyc = '0;
  endtask

  task automatic model_exec();
    logic [31:0] in, a, b, si, pc4, npc, v;
    int d;
    logic w;
    in = prog[m_pc[7:2]];
    a = m_reg[in[25:21]];
    b = m_reg[in[20:16]];
    si = {{16{in[15]}}, in[15:0]};
    pc4 = m_pc + 4;
    npc = pc4;
    d = int'(in[20:16]);
    w = 1'b1;
    v = '0;
    case (in[31:26])
      6'h00: begin
        d = int'(in[15:11]);
        case (in[5:0])
          6'h21: v = a + b;
          6'h23: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: v = b << in[10:6];
          default: w = 1'b0;
        endcase
      end
      6'h09: v = a + si;
      6'h0D: v = a | {16'd0, in[15:0]};
      6'h0F: v = {in[15:0], 16'd0};
      6'h23: v = m_mem[((a + si) >> 2) % 64];
      6'h2B: begin m_mem[((a + si) >> 2) % 64] = b; w = 1'b0; end
      6'h04: begin w = 1'b0; if (a == b) npc = pc4 + (si << 2); end
      6'h05: begin w = 1'b0; if (a != b) npc = pc4 + (si << 2); end
      6'h02: begin w = 1'b0; npc = {pc4[31:28], in[25:0], 2'b00}; end
      default: w = 1'b0;
    endcase
    if (w && d != 0) m_reg[d] = v;
    m_pc = npc % 256;
    m_cyc = m_cyc + 1;
  endtask

  function automatic logic [11:0] exp_led(input logic [7:0] s);
    logic [31:0] r;
    r = m_reg[s[4:0]];
    case (s[7:5])
      3'd0: return m_pc[11:0];
      3'd1: return r[11:0];
      3'd2: return r[23:12];
      3'd3: return {4'd0, r[31:24]};
      3'd4: return prog[m_pc[7:2]][11:0];
      3'd5: return m_cyc[11:0];
      default: return 12'd0;
    endcase
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.rom[i] = prog[i];
  endtask

  task automatic step();
    @(posedge clk);
    if (rst && gclk) model_exec();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) prog[i] = $urandom;
    load_prog();
    for (int c = 0; c < 250; c++) begin
      gclk = c[0];
      step();
      led_sel = 8'h00; #1; vec++;
      if (led !== 12'd0) begin bad++; $display("FAIL reset_pc cyc=%0d got=%h exp=000", c, led); end
      led_sel = {3'b001, 5'($urandom)}; #1; vec++;
      if (led !== 12'd0) begin bad++; $display("FAIL reset_reg cyc=%0d got=%h exp=000", c, led); end
      led_sel = {3'b101, 5'd0}; #1; vec++;
      if (led !== 12'd0) begin bad++; $display("FAIL reset_cyc cyc=%0d got=%h exp=000", c, led); end
    end
  endtask

  task automatic test_directed();
    logic [11:0] exp_lo [6];
    for (int i = 0; i < 64; i++) prog[i] = '0;
    prog[0] = i_ins(9, 0, 1, 16'd5);
    prog[1] = i_ins(9, 1, 2, 16'hFFFD);
    prog[2] = r_ins(1, 2, 3, 0, 6'h23);
    prog[3] = i_ins(15, 0, 4, 16'hABCD);
    prog[4] = i_ins(13, 4, 4, 16'h1234);
    prog[5] = i_ins(6'h2B, 0, 1, 16'd8);
    prog[6] = i_ins(6'h23, 0, 5, 16'd8);
    prog[7] = i_ins(9, 0, 0, 16'd7);
    prog[8] = 32'hFC21_FFFF;
    prog[9] = i_ins(4, 0, 0, 16'hFFFF);
    load_prog();
    model_reset();
    rst = 1'b1;
    gclk = 1'b1;
    for (int i = 0; i < 3; i++) step();
    led_sel = {3'b001, 5'd3}; #1; vec++;
    if (led !== 12'd3) begin bad++; $display("FAIL subu_r3 got=%h exp=003", led); end
    led_sel = 8'h00; #1; vec++;
    if (led !== 12'd12) begin bad++; $display("FAIL pc_after3 got=%h exp=00c", led); end
    step(); step();
    led_sel = {3'b010, 5'd4}; #1; vec++;
    if (led !== 12'hCD1) begin bad++; $display("FAIL lui_ori_mid got=%h exp=cd1", led); end
    led_sel = {3'b011, 5'd4}; #1; vec++;
    if (led !== 12'h0AB) begin bad++; $display("FAIL lui_ori_hi got=%h exp=0ab", led); end
    step(); step();
    led_sel = {3'b001, 5'd5}; #1; vec++;
    if (led !== 12'd5) begin bad++; $display("FAIL sw_lw_r5 got=%h exp=005", led); end
    step();
    led_sel = {3'b001, 5'd0}; #1; vec++;
    if (led !== 12'd0) begin bad++; $display("FAIL r0_write got=%h exp=000", led); end
    step();
    led_sel = 8'h00; #1; vec++;
    if (led !== 12'd36) begin bad++; $display("FAIL unsupported_pc got=%h exp=024", led); end
    exp_lo = '{12'd0, 12'd5, 12'd2, 12'd3, 12'h234, 12'd5};
    for (int r = 1; r < 6; r++) begin
      led_sel = {3'b001, 5'(r)}; #1; vec++;
      if (led !== exp_lo[r]) begin bad++; $display("FAIL unsupported_reg r%0d got=%h exp=%h", r, led, exp_lo[r]); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      led_sel = 8'h00; #1; vec++;
      if (led !== 12'd36) begin bad++; $display("FAIL loop_pc i=%0d got=%h exp=024", i, led); end
      led_sel = 8'hA0; #1; vec++;
      if (led !== 12'(10 + i)) begin bad++; $display("FAIL loop_cyc i=%0d got=%h exp=%h", i, led, 12'(10 + i)); end
    end
    gclk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      led_sel = 8'hA0; #1; vec++;
      if (led !== 12'd13) begin bad++; $display("FAIL freeze_cyc i=%0d got=%h exp=00d", i, led); end
    end
    rst = 1'b0;
    model_reset();
    #1;
    led_sel = 8'h00; #1; vec++;
    if (led !== 12'd0) begin bad++; $display("FAIL async_reset_pc got=%h exp=000", led); end
    step();
    for (int r = 1; r < 6; r++) begin
      led_sel = {3'b001, 5'(r)}; #1; vec++;
      if (led !== 12'd0) begin bad++; $display("FAIL reset_clear r%0d got=%h exp=000", r, led); end
    end
    prog[0] = i_ins(6'h23, 0, 6, 16'd8);
    load_prog();
    rst = 1'b1;
    gclk = 1'b1;
    step();
    led_sel = {3'b001, 5'd6}; #1; vec++;
    if (led !== 12'd5) begin bad++; $display("FAIL ram_survives_reset got=%h exp=005", led); end
    led_sel = 8'h00; #1; vec++;
    if (led !== 12'd4) begin bad++; $display("FAIL post_reset_pc got=%h exp=004", led); end
  endtask

  function automatic logic [31:0] rand_ins();
    int rs, rt, rd;
    logic [5:0] fns [6];
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00};
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    rd = $urandom_range(0, 7);
    case ($urandom_range(0, 12))
      0, 1, 2: return r_ins(rs, rt, rd, $urandom_range(0, 31), fns[$urandom_range(0, 5)]);
      3, 4:    return i_ins(9, rs, rt, 16'($urandom));
      5:       return i_ins(13, rs, rt, 16'($urandom));
      6:       return i_ins(15, 0, rt, 16'($urandom));
      7:       return i_ins(6'h23, rs, rt, 16'($urandom));
      8:       return i_ins(6'h2B, rs, rt, 16'($urandom));
      9:       return i_ins($urandom_range(4, 5), rs, rt, 16'($urandom_range(0, 15) - 8));
      10:      return {6'h02, 26'($urandom)};
      11:      return {6'h3F, 26'($urandom)};
      default: return r_ins(rs, rt, rd, 0, 6'h20);
    endcase
  endfunction

  task automatic test_random();
    logic [7:0] s;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 64; i++) prog[i] = rand_ins();
      load_prog();
      do_reset();
      for (int c = 0; c < 80; c++) begin
        gclk = ($urandom_range(0, 3) != 0);
        step();
        for (int k = 0; k < 3; k++) begin
          s = (k == 0) ? 8'h00 : 8'($urandom);
          led_sel = s; #1; vec++;
          if (led !== exp_led(s)) begin
            bad++;
            $display("FAIL random p=%0d c=%0d sel=%h got=%h exp=%h", p, c, s, led, exp_led(s));
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin dut.ram[i] = '0; m_mem[i] = '0; end
    model_reset();
    test_reset();
    test_directed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
